// File: rtl/lgn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lgn_pkg
// Description : Shared defaults, typedefs and state encoding for the lgn
//               class-vote readout stage.
// Revision    : 1.0 - initial release
// ============================================================================
package lgn_pkg;

    localparam int LGN_IN_W           = 16;
    localparam int LGN_NUM_CLASSES    = 10;
    localparam int LGN_BITS_PER_CLASS = 64;

    localparam int LGN_CLS_W   = $clog2(LGN_NUM_CLASSES);
    localparam int LGN_SCORE_W = $clog2(LGN_BITS_PER_CLASS + 1);

    typedef logic [LGN_CLS_W-1:0]   class_idx_t;
    typedef logic [LGN_SCORE_W-1:0] score_t;

    // Framing state of the input side of the voter
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } vote_state_e;

endpackage : lgn_pkg
`default_nettype wire

// File: rtl/lgn_popcount.sv
`default_nettype none
// ============================================================================
// Module      : lgn_popcount
// Description : Combinational population count of a W-bit vector. Written as
//               a reduction loop; synthesis balances it into an adder tree.
// Revision    : 1.0 - initial release
// ============================================================================
module lgn_popcount #(
    parameter  int W  = 16,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] count
);

    // Sum of all set bits in the input vector
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule : lgn_popcount
`default_nettype wire

// File: rtl/lgn_class_vote.sv
`default_nettype none
// ============================================================================
// Module      : lgn_class_vote
// Description : Popcounts the lgn network output bits per class group and
//               registers the argmax class and its score once per frame.
//               Pipeline: input framing + popcount (stage 1), per-class
//               accumulate/compare (stage 2), result register.
// Revision    : 1.0 - initial release
// ============================================================================
module lgn_class_vote
    import lgn_pkg::*;
#(
    parameter  int IN_W            = LGN_IN_W,
    parameter  int NUM_CLASSES     = LGN_NUM_CLASSES,
    parameter  int BITS_PER_CLASS  = LGN_BITS_PER_CLASS,
    localparam int BEATS_PER_CLASS = BITS_PER_CLASS / IN_W,
    localparam int CLS_W           = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
    localparam int SCORE_W         = $clog2(BITS_PER_CLASS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [IN_W-1:0]    in_bits,
    input  logic               in_last,
    output logic               out_valid,
    output logic [CLS_W-1:0]   out_class,
    output logic [SCORE_W-1:0] out_score,
    output logic               out_err
);

    localparam int BEAT_W = (BEATS_PER_CLASS > 1) ? $clog2(BEATS_PER_CLASS) : 1;
    localparam int PC_W   = $clog2(IN_W + 1);

    if ((BITS_PER_CLASS % IN_W) != 0) begin : g_cfg_check
        $error("lgn_class_vote: BITS_PER_CLASS must be a multiple of IN_W");
    end

    vote_state_e          r_state;
    vote_state_e          w_next_state;
    logic [BEAT_W-1:0]    r_beat_cnt;
    logic [CLS_W-1:0]     r_cls_cnt;
    logic                 r_discard;

    logic                 w_accept;
    logic                 w_start;
    logic                 w_beat_end;
    logic                 w_full;
    logic                 w_cls_end;
    logic                 w_frame_end;
    logic [PC_W-1:0]      w_pc;

    logic                 r_s1_valid;
    logic [PC_W-1:0]      r_s1_pc;
    logic [CLS_W-1:0]     r_s1_cls;
    logic                 r_s1_cls_end;
    logic                 r_s1_frame_end;
    logic                 r_s1_err;

    logic [SCORE_W-1:0]   r_acc;
    logic [SCORE_W-1:0]   w_acc_final;
    logic [SCORE_W-1:0]   r_best_score;
    logic [CLS_W-1:0]     r_best_cls;
    logic                 r_s2_done;
    logic                 r_s2_err;

    logic                 w_inflight;
    logic                 r_clr_pend;

    // Beats are taken unless we are draining an over-long frame up to its in_last
    assign w_accept    = in_valid && !r_discard;
    assign w_start     = w_accept && (r_state != ACCUM);
    assign w_beat_end  = (r_beat_cnt == BEAT_W'(BEATS_PER_CLASS - 1));
    assign w_full      = w_beat_end && (r_cls_cnt == CLS_W'(NUM_CLASSES - 1));
    assign w_cls_end   = w_beat_end || in_last;
    assign w_frame_end = w_full || in_last;

    lgn_popcount #(.W(IN_W)) u_popcount (
        .bits  (in_bits),
        .count (w_pc)
    );

    // Framing state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next state: an accepted beat either continues/opens a frame or closes it
    always_comb begin
        w_next_state = r_state;
        if (w_accept) begin
            w_next_state = w_frame_end ? DONE : ACCUM;
        end
    end

    // Beat/class position of the next beat, plus discard-until-in_last tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_cls_cnt  <= '0;
            r_discard  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_frame_end) begin
                    r_beat_cnt <= '0;
                    r_cls_cnt  <= '0;
                end else if (w_beat_end) begin
                    r_beat_cnt <= '0;
                    r_cls_cnt  <= r_cls_cnt + CLS_W'(1);
                end else begin
                    r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                end
            end
            if (w_accept && w_full && !in_last) r_discard <= 1'b1;
            else if (in_valid && r_discard && in_last) r_discard <= 1'b0;
        end
    end

    // Stage 1: register beat popcount and its framing flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid     <= 1'b0;
            r_s1_pc        <= '0;
            r_s1_cls       <= '0;
            r_s1_cls_end   <= 1'b0;
            r_s1_frame_end <= 1'b0;
            r_s1_err       <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_pc        <= w_pc;
                r_s1_cls       <= r_cls_cnt;
                r_s1_cls_end   <= w_cls_end;
                r_s1_frame_end <= w_frame_end;
                r_s1_err       <= w_full ^ in_last;
            end
        end
    end

    assign w_acc_final = r_acc + SCORE_W'(r_s1_pc);

    // Stage 2: accumulate per class; strict-greater compare keeps the lowest index on ties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc        <= '0;
            r_best_score <= '0;
            r_best_cls   <= '0;
            r_s2_done    <= 1'b0;
            r_s2_err     <= 1'b0;
        end else begin
            r_s2_done <= r_s1_valid && r_s1_frame_end;
            if (r_s1_valid) begin
                r_acc <= r_s1_cls_end ? '0 : w_acc_final;
                if (r_s1_cls_end && ((r_s1_cls == '0) || (w_acc_final > r_best_score))) begin
                    r_best_score <= w_acc_final;
                    r_best_cls   <= r_s1_cls;
                end
                if (r_s1_frame_end) r_s2_err <= r_s1_err;
            end
        end
    end

    // A frame result still travelling through the pipeline
    assign w_inflight = (r_s1_valid && r_s1_frame_end) || r_s2_done;

    // Result register. A new frame start drops out_valid; if the previous
    // result has not been presented yet, it is shown for one cycle first and
    // the drop is deferred, so every result is announced by a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_class  <= '0;
            out_score  <= '0;
            out_err    <= 1'b0;
            r_clr_pend <= 1'b0;
        end else begin
            if (r_s2_done) begin
                out_valid <= 1'b1;
                out_class <= r_best_cls;
                out_score <= r_best_score;
                out_err   <= r_s2_err;
            end else if (w_start || r_clr_pend) begin
                out_valid <= 1'b0;
                out_err   <= 1'b0;
            end
            if (w_start && w_inflight) r_clr_pend <= 1'b1;
            else if (!r_s2_done)       r_clr_pend <= 1'b0;
        end
    end

endmodule : lgn_class_vote
`default_nettype wire

// File: tb/tb_lgn_class_vote.sv
`default_nettype none
// ============================================================================
// Module      : tb_lgn_class_vote
// Description : Self-checking bench for lgn_class_vote. The driver pushes the
//               expected result of each frame into a scoreboard queue; an
//               independent monitor pops and compares on each out_valid rise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lgn_class_vote;
    import lgn_pkg::*;

    localparam int IN_W  = 16;
    localparam int NC    = 10;
    localparam int BPC   = 64;
    localparam int BEATS = BPC / IN_W;
    localparam int FRAME = NC * BEATS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_bits = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic [3:0]  out_class;
    logic [6:0]  out_score;
    logic        out_err;

    typedef struct {
        int cls;
        int score;
        int err;
        int cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] fb[0:63];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fails = 0;

    lgn_class_vote #(
        .IN_W           (IN_W),
        .NUM_CLASSES    (NC),
        .BITS_PER_CLASS (BPC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bits   (in_bits),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_class (out_class),
        .out_score (out_score),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_fb(input logic [15:0] v);
        for (int i = 0; i < 64; i++) fb[i] = v;
    endtask

    // Drive n beats from fb; the result is expected 2 cycles after the frame-ending beat
    task automatic send_frame(input int n, input bit bub, input int ecls, input int escore, input int eerr);
        int fe;
        fe = (n < FRAME) ? n : FRAME;
        for (int i = 0; i < n; i++) begin
            if (bub && ($urandom_range(0, 3) == 0)) idle(1);
            if (i == fe - 1) begin
                exp_t e;
                e.cls = ecls; e.score = escore; e.err = eerr; e.cyc = cyc + 3;
                sb.push_back(e);
            end
            in_valid = 1'b1;
            in_bits  = fb[i];
            in_last  = (i == n - 1);
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Reference argmax over the first min(n, FRAME) beats of fb
    task automatic golden(input int n, output int ecls, output int escore);
        int lim;
        int best;
        int s;
        bit any;
        lim = (n < FRAME) ? n : FRAME;
        best = -1; ecls = 0; escore = 0;
        for (int c = 0; c < NC; c++) begin
            s = 0; any = 1'b0;
            for (int b = 0; b < BEATS; b++) begin
                if (c * BEATS + b < lim) begin
                    s += $countones(fb[c * BEATS + b]);
                    any = 1'b1;
                end
            end
            if (any && (c == 0 || s > best)) begin
                best = s; ecls = c; escore = s;
            end
        end
    endtask

    initial begin
        int gcls, gscore;
        int gaps[6];
        gaps = '{0, 0, 1, 3, 0, 2};

        fork
            begin : monitor
                logic prev_v;
                exp_t e;
                prev_v = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        prev_v = 1'b0;
                    end else begin
                        if (out_valid && !prev_v) begin
                            if (sb.size() == 0) begin
                                n_tests++;
                                n_fails++;
                                $display("FAIL unexpected_result: class=%0d score=%0d err=%0d, expected no result", out_class, out_score, out_err);
                            end else begin
                                e = sb.pop_front();
                                check("out_class", int'(out_class), e.cls);
                                check("out_score", int'(out_score), e.score);
                                check("out_err", int'(out_err), e.err);
                                check("latency_cycle", cyc, e.cyc);
                            end
                        end
                        prev_v = out_valid;
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_class", int'(out_class), 0);
        check("rst_out_score", int'(out_score), 0);
        check("rst_out_err", int'(out_err), 0);
        check("rst_state", int'(dut.r_state), int'(IDLE));
        rst = 1'b0;
        idle(2);

        // Class 3 all ones, everything else zero
        clear_fb(16'h0000);
        for (int i = 12; i < 16; i++) fb[i] = 16'hFFFF;
        send_frame(FRAME, 1'b0, 3, 64, 0);
        idle(4);

        // Classes 2 and 7 tie at 40; class 0 scores 1
        clear_fb(16'h0000);
        fb[0] = 16'h0001;
        fb[8]  = 16'hFFFF; fb[9]  = 16'hFFFF; fb[10] = 16'h00FF;
        fb[28] = 16'hFFFF; fb[29] = 16'hFFFF; fb[30] = 16'h00FF;
        send_frame(FRAME, 1'b0, 2, 40, 0);
        idle(4);

        // Early in_last at beat 20: class 5 partial (16) beats class 1 (12)
        clear_fb(16'h0000);
        for (int i = 4; i < 8; i++) fb[i] = 16'h0007;
        fb[20] = 16'hFFFF;
        send_frame(21, 1'b0, 5, 16, 1);
        idle(4);

        // Missing in_last: frame ends at beat 39, beats 40..43 discarded
        clear_fb(16'h0000);
        for (int i = 36; i < 44; i++) fb[i] = 16'hFFFF;
        send_frame(44, 1'b0, 9, 64, 1);
        idle(4);

        // Random frames, random bubbles, mostly back-to-back
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < FRAME; i++) fb[i] = 16'($urandom) & 16'($urandom);
            golden(FRAME, gcls, gscore);
            send_frame(FRAME, 1'b1, gcls, gscore, 0);
            idle(gaps[f]);
        end
        idle(6);

        // Reset pulse in the middle of a frame, then a clean frame won by class 9
        for (int i = 0; i < 25; i++) begin
            in_valid = 1'b1;
            in_bits  = 16'($urandom);
            in_last  = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", int'(out_valid), 0);
        check("async_rst_out_class", int'(out_class), 0);
        check("async_rst_out_score", int'(out_score), 0);
        check("async_rst_out_err", int'(out_err), 0);
        check("async_rst_state", int'(dut.r_state), int'(IDLE));
        idle(2);
        rst = 1'b0;
        idle(1);
        clear_fb(16'h0003);
        for (int i = 36; i < 39; i++) fb[i] = 16'hFFFF;
        send_frame(FRAME, 1'b0, 9, 50, 0);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        check("pending_results", sb.size(), 0);
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule : tb_lgn_class_vote
`default_nettype wire
